// File: rtl/bin_enc_iter.sv
// Sequential binary encoder: accepts a bit vector and emits the index of every
// active bit, one per handshake beat, in LSB-first or MSB-first priority order.
module bin_enc_iter #(
    parameter int OUT  = 3,
    parameter int IN   = 1 << OUT,
    parameter bit ACT  = 1'b1,   // 1: a 1 bit is active, 0: a 0 bit is active
    parameter bit MODE = 1'b0    // 0: lowest index first, 1: highest index first
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IN-1:0]  in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OUT-1:0] out,
    output logic           out_last,
    output logic           none
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        NONE
    } state_t;

    state_t          state_q, state_d;
    logic [IN-1:0]   vec_q, vec_d;
    logic [IN-1:0]   vec_in;
    logic [IN-1:0]   clr_mask;
    logic [OUT-1:0]  idx;
    logic            one_left;

    assign vec_in = ACT ? in : ~in;

    // Priority search: the last match in loop order wins, so the loop direction
    // is the reverse of the scan order.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment,
        // so no path leaves it unassigned and no latch is inferred.
        idx = '0;
        if (MODE == 1'b0) begin
            for (int i = IN - 1; i >= 0; i--) begin
                if (vec_q[i]) idx = OUT'(i);
            end
        end else begin
            for (int i = 0; i < IN; i++) begin
                if (vec_q[i]) idx = OUT'(i);
            end
        end
    end

    assign one_left = (vec_q != '0) && ((vec_q & (vec_q - IN'(1))) == '0);
    assign clr_mask = IN'(1) << idx;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d   = vec_in;
                    state_d = (vec_in != '0) ? SCAN : NONE;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    vec_d = vec_q & ~clr_mask;
                    if (one_left) state_d = IDLE;
                end
            end
            NONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    // Handshake flags decode straight from the state register; index outputs
    // are forced to zero whenever no beat is presented.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SCAN);
    assign none      = (state_q == NONE);
    assign out       = out_valid ? idx : '0;
    assign out_last  = out_valid & one_left;

endmodule

// File: tb/tb_bin_enc_iter.sv
// Directed bench for bin_enc_iter: three instances (LSB-first, MSB-first,
// active-low) share stimulus; each test resets all and checks one instance.
module tb_bin_enc_iter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in;
    logic       out_ready;

    logic [2:0]      rdy, ov, lst, nn;
    logic [2:0][2:0] ox;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_enc_iter #(.OUT(3), .MODE(1'b0), .ACT(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .in(in),
        .out_valid(ov[0]), .out_ready(out_ready), .out(ox[0]), .out_last(lst[0]), .none(nn[0]));
    bin_enc_iter #(.OUT(3), .MODE(1'b1), .ACT(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .in(in),
        .out_valid(ov[1]), .out_ready(out_ready), .out(ox[1]), .out_last(lst[1]), .none(nn[1]));
    bin_enc_iter #(.OUT(3), .MODE(1'b0), .ACT(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]), .in(in),
        .out_valid(ov[2]), .out_ready(out_ready), .out(ox[2]), .out_last(lst[2]), .none(nn[2]));

    typedef struct {
        int         sel;
        logic [7:0] vec;
        int         n;
        int         b [3];
    } vec_t;

    vec_t tbl [16];
    int   ntbl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in        = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic add(input int sel, input logic [7:0] v, input int n,
                       input int b0, input int b1, input int b2);
        tbl[ntbl].sel  = sel;
        tbl[ntbl].vec  = v;
        tbl[ntbl].n    = n;
        tbl[ntbl].b[0] = b0;
        tbl[ntbl].b[1] = b1;
        tbl[ntbl].b[2] = b2;
        ntbl++;
    endtask

    task automatic run_vec(input vec_t t);
        int s;
        s = t.sel;
        do_reset();
        check($sformatf("rst_ready[%0d]", s), 32'(rdy[s]), 1);
        check($sformatf("rst_valid[%0d]", s), 32'(ov[s] | nn[s] | lst[s] | (|ox[s])), 0);
        in       = t.vec;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (t.n == 0) begin
            check($sformatf("none_pulse[%0h]", t.vec), 32'(nn[s]), 1);
            check($sformatf("none_noval[%0h]", t.vec), 32'(ov[s]), 0);
            check($sformatf("none_busy[%0h]", t.vec), 32'(rdy[s]), 0);
            tick();
            check($sformatf("none_end[%0h]", t.vec), 32'(nn[s]), 0);
        end else begin
            for (int j = 0; j < t.n; j++) begin
                check($sformatf("valid[%0d:%0h:%0d]", s, t.vec, j), 32'(ov[s]), 1);
                check($sformatf("out[%0d:%0h:%0d]", s, t.vec, j), 32'(ox[s]), 32'(t.b[j]));
                check($sformatf("last[%0d:%0h:%0d]", s, t.vec, j), 32'(lst[s]), 32'(j == t.n - 1));
                check($sformatf("busy[%0d:%0h:%0d]", s, t.vec, j), 32'(rdy[s]), 0);
                tick();
            end
        end
        check($sformatf("ready_after[%0d:%0h]", s, t.vec), 32'(rdy[s]), 1);
        check($sformatf("idle_out[%0d:%0h]", s, t.vec), 32'(ov[s] | (|ox[s]) | lst[s]), 0);
    endtask

    initial begin
        ntbl = 0;
        for (int i = 0; i < 8; i++) add(0, 8'(1 << i), 1, i, 0, 0);
        add(0, 8'hA4, 3, 2, 5, 7);
        add(1, 8'hA4, 3, 7, 5, 2);
        add(1, 8'h80, 1, 7, 0, 0);
        add(2, 8'hFE, 1, 0, 0, 0);
        add(2, 8'hFF, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0);

        for (int k = 0; k < ntbl; k++) run_vec(tbl[k]);

        // Backpressure: first index held for three stalled cycles, then drains in order.
        do_reset();
        in        = 8'hA4;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("bp_valid", 32'(ov[0]), 1);
            check("bp_out", 32'(ox[0]), 2);
            check("bp_last", 32'(lst[0]), 0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_rel0", 32'(ox[0]), 2);
        tick();
        check("bp_rel1", 32'(ox[0]), 5);
        tick();
        check("bp_rel2", 32'(ox[0]), 7);
        check("bp_rel2_last", 32'(lst[0]), 1);
        tick();
        check("bp_done", 32'(rdy[0]), 1);

        // Held in_valid: a new vector presented mid-scan is only taken back in IDLE.
        do_reset();
        in       = 8'hA4;
        in_valid = 1'b1;
        tick();
        in = 8'h01;
        check("hold_b0", 32'(ox[0]), 2);
        tick();
        check("hold_b1", 32'(ox[0]), 5);
        tick();
        check("hold_b2", 32'(ox[0]), 7);
        tick();
        check("hold_idle", 32'(rdy[0]), 1);
        check("hold_idle_nv", 32'(ov[0]), 0);
        tick();
        in_valid = 1'b0;
        check("hold_new_valid", 32'(ov[0]), 1);
        check("hold_new_out", 32'(ox[0]), 0);
        check("hold_new_last", 32'(lst[0]), 1);
        tick();

        // Reset after the first handshake discards the rest of the vector.
        do_reset();
        in       = 8'hA4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid_b0", 32'(ox[0]), 2);
        tick();
        check("mid_b1", 32'(ox[0]), 5);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(ov[0]), 0);
        check("mid_rst_none", 32'(nn[0]), 0);
        reset = 1'b0;
        check("mid_rst_ready", 32'(rdy[0]), 1);
        in       = 8'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid_after_valid", 32'(ov[0]), 1);
        check("mid_after_out", 32'(ox[0]), 0);
        check("mid_after_last", 32'(lst[0]), 1);
        tick();
        check("mid_after_ready", 32'(rdy[0]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
